// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction-memory port, redirect and decode handshake, status and counters.
interface fetch_queue_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 16
);
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              deq_ready;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              halted;
    logic              illegal;
    logic [CNT_W-1:0]  fetch_count;
    logic [CNT_W-1:0]  flush_count;

    // fetch_queue side
    modport master (
        output imem_addr, instr_valid, instr, instr_pc, halted, illegal, fetch_count, flush_count,
        input  imem_rdata, redirect_valid, redirect_pc, deq_ready
    );

    // memory / decode / execute side
    modport slave (
        input  imem_addr, instr_valid, instr, instr_pc, halted, illegal, fetch_count, flush_count,
        output imem_rdata, redirect_valid, redirect_pc, deq_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, buffers {pc, word} pairs in a small FIFO
// ahead of decode, flushes on redirect and stops on the halt or illegal word.
module fetch_queue #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 4,
    parameter logic [ADDR_W-1:0] PC_STEP      = ADDR_W'(1),
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter logic [DATA_W-1:0] HALT_WORD    = '1,
    parameter logic [DATA_W-1:0] ILLEGAL_WORD = '0,
    parameter int unsigned CNT_W  = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.master bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] word;
    } entry_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        STOP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
    logic [OCC_W-1:0]  count, count_nxt;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
    logic              halted, halted_nxt;
    logic              illegal, illegal_nxt;
    logic [CNT_W-1:0]  fetch_count, fetch_count_nxt;
    logic [CNT_W-1:0]  flush_count, flush_count_nxt;
    logic              head_valid;
    logic              redirect;
    logic              pop;
    logic              push;
    logic              word_terminal;

    assign head = mem[rd_ptr];

    // Next-state, FIFO control and counter updates; redirect outranks push and pop
    always_comb begin
        state_nxt       = state;
        rd_ptr_nxt      = rd_ptr;
        wr_ptr_nxt      = wr_ptr;
        count_nxt       = count;
        fetch_pc_nxt    = fetch_pc;
        halted_nxt      = halted;
        illegal_nxt     = illegal;
        fetch_count_nxt = fetch_count;
        flush_count_nxt = flush_count;

        head_valid    = (count != '0) && (state != DONE);
        redirect      = bus.redirect_valid && (state != DONE);
        pop           = head_valid && bus.deq_ready && !redirect;
        push          = (state == RUN) && ((count < OCC_W'(DEPTH)) || pop) && !bus.redirect_valid;
        word_terminal = (bus.imem_rdata == HALT_WORD) || (bus.imem_rdata == ILLEGAL_WORD);

        if (redirect) begin
            rd_ptr_nxt      = wr_ptr;
            count_nxt       = '0;
            fetch_pc_nxt    = bus.redirect_pc;
            flush_count_nxt = flush_count + CNT_W'(count);
            state_nxt       = RUN;
        end else begin
            if (pop) begin
                rd_ptr_nxt = rd_ptr + PTR_W'(1);
            end
            if (push) begin
                wr_ptr_nxt      = wr_ptr + PTR_W'(1);
                fetch_pc_nxt    = fetch_pc + PC_STEP;
                fetch_count_nxt = fetch_count + CNT_W'(1);
            end
            count_nxt = count + OCC_W'(push) - OCC_W'(pop);

            case (state)
                RUN: begin
                    if (push && word_terminal) begin
                        state_nxt = STOP;
                    end
                end
                STOP: begin
                    // nothing is pushed after the terminal word, so it is the last entry
                    if (pop && (count == OCC_W'(1))) begin
                        state_nxt = DONE;
                        if (head.word == HALT_WORD) begin
                            halted_nxt = 1'b1;
                        end else begin
                            illegal_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            fetch_pc    <= RESET_PC;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            state       <= state_nxt;
            rd_ptr      <= rd_ptr_nxt;
            wr_ptr      <= wr_ptr_nxt;
            count       <= count_nxt;
            fetch_pc    <= fetch_pc_nxt;
            halted      <= halted_nxt;
            illegal     <= illegal_nxt;
            fetch_count <= fetch_count_nxt;
            flush_count <= flush_count_nxt;
        end
    end

    // Queue storage needs no reset: entries are only visible while counted
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= {fetch_pc, bus.imem_rdata};
        end
    end

    assign bus.imem_addr   = fetch_pc;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_valid ? head.word : '0;
    assign bus.instr_pc    = head_valid ? head.pc : '0;
    assign bus.halted      = halted;
    assign bus.illegal     = illegal;
    assign bus.fetch_count = fetch_count;
    assign bus.flush_count = flush_count;
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, compared every cycle
// against a queue-based reference model of the fetch front end.
module tb_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [15:0] HALT  = 16'hFFFF;
    localparam logic [15:0] ILL   = 16'h0000;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] word;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [15:0] imem [65536];

    ent_t        q[$];
    logic [15:0] m_pc, m_fc, m_flc;
    bit          m_stop, m_done, m_halt, m_ill;

    fetch_queue_if #(.DATA_W(16), .ADDR_W(16), .CNT_W(16)) bus ();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    assign bus.imem_rdata = imem[bus.imem_addr];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_default();
        for (int a = 0; a < 65536; a++) imem[a] = 16'h1000 + 16'(a);
    endtask

    task automatic model_reset();
        q.delete();
        m_pc = 16'h0; m_fc = 16'h0; m_flc = 16'h0;
        m_stop = 0; m_done = 0; m_halt = 0; m_ill = 0;
    endtask

    // Behavioural rules: redirect flushes, pop then push, terminal word ends fetch / execution
    task automatic model_update(input bit rv, input logic [15:0] rpc, input bit dr);
        bit          do_pop, do_push;
        logic [15:0] w;
        ent_t        e;
        if (m_done) return;
        if (rv) begin
            m_flc = m_flc + 16'(q.size());
            q.delete();
            m_pc = rpc;
            m_stop = 0;
            return;
        end
        do_pop  = (q.size() > 0) && dr;
        do_push = !m_stop && ((q.size() < DEPTH) || do_pop);
        w = imem[m_pc];
        if (do_pop) begin
            e = q.pop_front();
            if (e.word == HALT) begin m_halt = 1; m_done = 1; end
            else if (e.word == ILL) begin m_ill = 1; m_done = 1; end
        end
        if (do_push) begin
            q.push_back('{pc: m_pc, word: w});
            m_fc = m_fc + 16'h1;
            m_pc = m_pc + 16'h1;
            if (w == HALT || w == ILL) m_stop = 1;
        end
    endtask

    task automatic compare_all();
        bit v;
        v = !m_done && (q.size() > 0);
        check("imem_addr",   32'(bus.imem_addr),   32'(m_pc));
        check("instr_valid", 32'(bus.instr_valid), 32'(v));
        check("instr",       32'(bus.instr),       v ? 32'(q[0].word) : 32'h0);
        check("instr_pc",    32'(bus.instr_pc),    v ? 32'(q[0].pc) : 32'h0);
        check("halted",      32'(bus.halted),      32'(m_halt));
        check("illegal",     32'(bus.illegal),     32'(m_ill));
        check("fetch_count", 32'(bus.fetch_count), 32'(m_fc));
        check("flush_count", 32'(bus.flush_count), 32'(m_flc));
    endtask

    // One cycle: drive at the falling edge, compare current outputs, advance model past the rising edge
    task automatic step(input bit rst, input bit rv, input logic [15:0] rpc, input bit dr);
        reset = rst;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        bus.deq_ready = dr;
        #1;
        compare_all();
        if (rst) model_reset();
        else model_update(rv, rpc, dr);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0;
        bus.deq_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run(input int n, input bit dr);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, dr);
    endtask

    initial begin
        bit          rst, rv, dr;
        logic [15:0] w;

        fill_default();
        do_reset();

        // reset state and streaming at one instruction per cycle
        check("rst_imem_addr",   32'(bus.imem_addr), 32'h0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'h0);
        check("rst_instr",       32'(bus.instr), 32'h0);
        check("rst_fetch_count", 32'(bus.fetch_count), 32'h0);
        run(1, 1);
        check("first_valid", 32'(bus.instr_valid), 32'h1);
        check("first_pc",    32'(bus.instr_pc), 32'h0);
        check("first_instr", 32'(bus.instr), 32'h1000);
        run(3, 1);
        check("stream_fc4", 32'(bus.fetch_count), 32'h4);
        check("stream_pc3", 32'(bus.instr_pc), 32'h3);

        // decode stall fills the queue, then drains in order
        do_reset();
        run(10, 0);
        check("stall_addr", 32'(bus.imem_addr), 32'h4);
        check("stall_head", 32'(bus.instr_pc), 32'h0);
        check("stall_fc",   32'(bus.fetch_count), 32'h4);
        run(10, 1);

        // redirect on a full queue
        do_reset();
        run(6, 0);
        step(0, 1, 16'h0040, 1);
        check("redir_valid", 32'(bus.instr_valid), 32'h0);
        check("redir_addr",  32'(bus.imem_addr), 32'h40);
        check("redir_flush", 32'(bus.flush_count), 32'h4);
        run(1, 1);
        check("redir_head",  32'(bus.instr_pc), 32'h40);
        check("redir_instr", 32'(bus.instr), 32'h1040);

        // halt word at PC 5
        imem[5] = HALT;
        do_reset();
        run(12, 1);
        check("halt_flag",  32'(bus.halted), 32'h1);
        check("halt_ill",   32'(bus.illegal), 32'h0);
        check("halt_valid", 32'(bus.instr_valid), 32'h0);
        check("halt_addr",  32'(bus.imem_addr), 32'h6);
        check("halt_fc",    32'(bus.fetch_count), 32'h6);
        step(0, 1, 16'h0080, 1);
        check("halt_redir_addr", 32'(bus.imem_addr), 32'h6);
        check("halt_redir_flag", 32'(bus.halted), 32'h1);

        // reset from the halted state
        step(1, 0, 16'h0, 1);
        reset = 1'b0;
        check("rerst_addr",   32'(bus.imem_addr), 32'h0);
        check("rerst_valid",  32'(bus.instr_valid), 32'h0);
        check("rerst_instr",  32'(bus.instr), 32'h0);
        check("rerst_pc",     32'(bus.instr_pc), 32'h0);
        check("rerst_halted", 32'(bus.halted), 32'h0);
        check("rerst_fc",     32'(bus.fetch_count), 32'h0);
        check("rerst_flc",    32'(bus.flush_count), 32'h0);
        run(2, 1);
        check("rerst_head", 32'(bus.instr_pc), 32'h1);
        imem[5] = 16'h1005;

        // illegal word at PC 3 flushed by a redirect before it reaches decode
        imem[3] = ILL;
        do_reset();
        run(6, 0);
        check("ill_stop_addr", 32'(bus.imem_addr), 32'h4);
        step(0, 1, 16'h0020, 0);
        check("ill_redir_addr",  32'(bus.imem_addr), 32'h20);
        check("ill_redir_flush", 32'(bus.flush_count), 32'h4);
        run(1, 1);
        check("ill_resume_pc", 32'(bus.instr_pc), 32'h20);
        run(8, 1);
        check("ill_flag", 32'(bus.illegal), 32'h0);
        imem[3] = 16'h1003;

        // random program image and random redirect / stall / reset traffic
        for (int a = 0; a < 65536; a++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 99) < 2) w = HALT;
            else if ($urandom_range(0, 99) < 2) w = ILL;
            imem[a] = w;
        end
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst = m_done ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 299) == 0);
            rv  = ($urandom_range(0, 99) < 6);
            dr  = ($urandom_range(0, 99) < 70);
            step(rst, rv, 16'($urandom), dr);
        end
        step(0, 0, 16'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the pipelined processor. It owns the fetch PC, drives the combinational instruction memory, and buffers fetched words with their PCs in a DEPTH-entry FIFO ahead of decode. It accepts redirects (branch/jump resolution) by flushing queued entries, stops fetching on the halt or illegal word, and keeps fetch and flush performance counters.

## Interface
- DATA_W, 16, instruction width
- ADDR_W, 16, PC / instruction-memory address width
- DEPTH, 4, FIFO entries; power of two, >= 2
- PC_STEP, 1, fetch PC increment per instruction
- RESET_PC, 0, fetch PC after reset
- HALT_WORD, all ones, instruction that ends execution normally
- ILLEGAL_WORD, 0, instruction that ends execution as invalid
- CNT_W, 16, performance counter width
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_addr  out  ADDR_W  address to combinational instruction memory (= fetch PC)
- imem_rdata  in  DATA_W  instruction at imem_addr, valid the same cycle
- redirect_valid  in  1  decode/execute requests PC change
- redirect_pc  in  ADDR_W  target PC for redirect
- deq_ready  in  1  decode accepts head entry this cycle (not stalled)
- instr_valid  out  1  head entry present
- instr  out  DATA_W  head instruction; 0 when instr_valid=0
- instr_pc  out  ADDR_W  PC of head instruction; 0 when instr_valid=0
- halted  out  1  sticky: HALT_WORD dequeued
- illegal  out  1  sticky: ILLEGAL_WORD dequeued
- fetch_count  out  CNT_W  entries pushed since reset
- flush_count  out  CNT_W  entries discarded by redirects since reset

## Operation
- FIFO: DEPTH entries of {pc, word}, read pointer, write pointer, count 0..DEPTH; pointers wrap modulo DEPTH.
- pop = instr_valid & deq_ready. push = (state==RUN) & (count<DEPTH | pop) & ~redirect_valid.
- Push stores {fetch_pc, imem_rdata}; fetch_pc += PC_STEP (mod 2^ADDR_W, wraps).
- States: RUN (fetching), STOP (terminal word enqueued, no further fetch), DONE (terminal word dequeued, frozen).
- RUN -> STOP when pushed word equals HALT_WORD or ILLEGAL_WORD; that word is still enqueued.
- STOP -> DONE when the terminal entry is popped; set halted or illegal accordingly. Entries ahead of it pop normally.
- Redirect (state RUN or STOP): discard all entries (count->0, rd=wr), fetch_pc<=redirect_pc, state->RUN, flush_count += count, no push and no pop that cycle. Redirect has priority over push and pop.
- DONE: redirect_valid, deq_ready ignored; no push; instr_valid=0; all state holds until reset.
- Counters wrap at 2^CNT_W. fetch_count increments on every push.
- Full with pop: push and pop in the same cycle, count unchanged. Empty: pop impossible (instr_valid=0).

## Timing
- Reset values: fetch_pc=RESET_PC, count=0, state RUN, instr_valid=0, instr=0, instr_pc=0, halted=0, illegal=0, both counters 0; imem_addr=RESET_PC.
- Reset has priority over every other input; reset mid-operation discards queue and status in one cycle.
- Fetch-to-decode latency 1 cycle: word fetched in cycle N is at the head (if queue was empty) in cycle N+1.
- Redirect in cycle N: imem_addr=redirect_pc in N+1, that instruction valid at head in N+2.
- Sustained throughput 1 instruction/cycle with deq_ready held high.
- halted/illegal assert the cycle after the terminal entry is popped.
- imem_addr, instr, instr_pc, instr_valid are registered-state functions only (no combinational path from deq_ready or redirect_valid).

## Test plan
- Reset, deq_ready=1, imem returns word = 0x1000+addr: instr_valid rises cycle 1 with instr_pc=0, instr=0x1000; PCs 0,1,2,3 on consecutive cycles; fetch_count=4 after 4 pushes.
- deq_ready=0 for 10 cycles: count reaches DEPTH=4, fetch_pc stops at 4, head stays PC 0; release -> PCs 0..7 in order, no loss or duplicate.
- Full queue, redirect_valid=1 with redirect_pc=0x40: next cycle instr_valid=0, imem_addr=0x40, flush_count=4; following cycle head instr_pc=0x40.
- Word at PC 5 = 0xFFFF: fetch stops with imem_addr=6; after popping PCs 0..5, halted=1, instr_valid=0; later redirect ignored.
- Word at PC 3 = 0x0000 with redirect to 0x20 issued while in STOP before PC 3 pops: illegal stays 0, fetch resumes at 0x20.
- Assert reset while halted with count=0 and counters nonzero: all outputs return to reset values next cycle, fetch restarts at RESET_PC.
